// File: rtl/multi_tick_stopwatch.sv
// multi_tick_stopwatch
//
// Shared prescaler feeding N_CH independent stopwatch channels. The prescaler
// produces a one-cycle `tick` every CLK_PER_TICK clock cycles. Each channel
// has an IDLE / RUN / HOLD controller and counts ticks while running. Overflow
// either wraps the count to zero or saturates it at all-ones (WRAP parameter),
// and in both cases sets a sticky per-channel overflow flag.
//
// Ports
//   clk      in  1            rising-edge clock
//   rst      in  1            synchronous, active-high reset
//   start    in  N_CH         start / resume request per channel
//   stop     in  N_CH         stop request per channel
//   clear    in  N_CH         clear request per channel (highest priority)
//   tick     out 1            registered prescaler pulse
//   cnt      out N_CH*CNT_W   channel i count at [i*CNT_W +: CNT_W]
//   running  out N_CH         channel i is in RUN
//   ovf      out N_CH         sticky overflow flag
//   done     out N_CH         one-cycle pulse on RUN -> HOLD via stop
//
// Every output is driven straight from a flop.

module multi_tick_stopwatch #(
  parameter int CLK_PER_TICK = 100000,
  parameter int CNT_W        = 16,
  parameter int N_CH         = 4,
  parameter bit WRAP         = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         stop,
  input  logic [N_CH-1:0]         clear,
  output logic                    tick,
  output logic [N_CH*CNT_W-1:0]   cnt,
  output logic [N_CH-1:0]         running,
  output logic [N_CH-1:0]         ovf,
  output logic [N_CH-1:0]         done
);

  localparam int            PW        = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Returns {overflow, next_count} for one counted tick. At all-ones the count
  // either wraps to zero or stays pinned, depending on WRAP.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (&v) begin
      if (WRAP) r = {1'b1, {CNT_W{1'b0}}};
      else      r = {1'b1, v};
    end else begin
      r = {1'b0, v + 1'b1};
    end
    return r;
  endfunction

  logic [PW-1:0]                presc_q, presc_d;
  logic                         tick_q, tick_d;
  state_t                       state_q [N_CH];
  state_t                       state_d [N_CH];
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]              running_q, running_d;
  logic [N_CH-1:0]              ovf_q, ovf_d;
  logic [N_CH-1:0]              done_q, done_d;
  logic [CNT_W:0]               step_v;

  // Prescaler: free-running 0..CLK_PER_TICK-1, tick registered on the terminal value
  always_comb begin
    tick_d = (presc_q == PRESC_MAX);
    if (presc_q == PRESC_MAX) presc_d = '0;
    else                      presc_d = presc_q + 1'b1;
  end

  // Channel controllers: clear > stop > start; counting only when RUN, ticking,
  // and no stop/clear is pending in the same cycle
  always_comb begin
    step_v = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i];
      done_d[i]  = 1'b0;
      if (clear[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        ovf_d[i]   = 1'b0;
      end else if (stop[i]) begin
        if (state_q[i] == ST_RUN) begin
          state_d[i] = ST_HOLD;
          done_d[i]  = 1'b1;
        end
      end else if (start[i] && (state_q[i] != ST_RUN)) begin
        // Resuming from HOLD keeps the held count (lap accumulation).
        state_d[i] = ST_RUN;
      end else if ((state_q[i] == ST_RUN) && tick_q) begin
        step_v   = cnt_step(cnt_q[i]);
        cnt_d[i] = step_v[CNT_W-1:0];
        ovf_d[i] = ovf_q[i] | step_v[CNT_W];
      end
      running_d[i] = (state_d[i] == ST_RUN);
    end
  end

  // Register stage: all state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      running_q <= '0;
      ovf_q     <= '0;
      done_q    <= '0;
      for (int i = 0; i < N_CH; i++) state_q[i] <= ST_IDLE;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
    end
  end

  assign tick    = tick_q;
  assign cnt     = cnt_q;
  assign running = running_q;
  assign ovf     = ovf_q;
  assign done    = done_q;

endmodule

// File: tb/tb_multi_tick_stopwatch.sv
module tb_multi_tick_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] stop  = '0;
  logic [1:0] clear = '0;

  logic       tick_w, tick_s;
  logic [7:0] cnt_w, cnt_s;
  logic [1:0] run_w, run_s, ovf_w, ovf_s, done_w, done_s;
  logic [29:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model: cycle index since reset release plus per-channel
  // running/overflow/done flags and integer counts for both overflow modes.
  int         m_cyc;
  logic [1:0] m_run, m_ovf, m_done;
  int         m_cw [2];
  int         m_cs [2];

  always #5 clk = ~clk;

  multi_tick_stopwatch #(.CLK_PER_TICK(4), .CNT_W(4), .N_CH(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .tick(tick_w), .cnt(cnt_w), .running(run_w), .ovf(ovf_w), .done(done_w));

  multi_tick_stopwatch #(.CLK_PER_TICK(4), .CNT_W(4), .N_CH(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .tick(tick_s), .cnt(cnt_s), .running(run_s), .ovf(ovf_s), .done(done_s));

  assign obs = {tick_w, tick_s, cnt_w, cnt_s, run_w, run_s, ovf_w, ovf_s, done_w, done_s};

  // Tick is high in cycles 4, 8, 12, ... after reset release.
  function automatic logic m_tick();
    return (m_cyc > 0) && ((m_cyc % 4) == 0);
  endfunction

  function automatic logic [29:0] exp_vec();
    logic [3:0] w0, w1, s0, s1;
    w0 = m_cw[0][3:0]; w1 = m_cw[1][3:0];
    s0 = m_cs[0][3:0]; s1 = m_cs[1][3:0];
    return {m_tick(), m_tick(), w1, w0, s1, s0, m_run, m_run, m_ovf, m_ovf, m_done, m_done};
  endfunction

  task automatic do_reset(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] cl);
    rst = 1'b1; start = st; stop = sp; clear = cl;
    @(posedge clk);
    m_cyc = 0; m_run = '0; m_ovf = '0; m_done = '0;
    for (int c = 0; c < 2; c++) begin m_cw[c] = 0; m_cs[c] = 0; end
    #1;
    rst = 1'b0; start = '0; stop = '0; clear = '0;
  endtask

  task automatic step(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] cl);
    logic tk;
    start = st; stop = sp; clear = cl;
    @(posedge clk);
    tk = m_tick();
    for (int c = 0; c < 2; c++) begin
      m_done[c] = 1'b0;
      if (cl[c]) begin
        m_run[c] = 1'b0; m_cw[c] = 0; m_cs[c] = 0; m_ovf[c] = 1'b0;
      end else if (sp[c]) begin
        if (m_run[c]) begin m_run[c] = 1'b0; m_done[c] = 1'b1; end
      end else if (st[c] && !m_run[c]) begin
        m_run[c] = 1'b1;
      end else if (m_run[c] && tk) begin
        if (m_cw[c] == 15) m_ovf[c] = 1'b1;
        m_cw[c] = (m_cw[c] + 1) % 16;
        m_cs[c] = (m_cs[c] == 15) ? 15 : m_cs[c] + 1;
      end
    end
    m_cyc++;
    #1;
    start = '0; stop = '0; clear = '0;
  endtask

  task automatic test_reset();
    do_reset(2'b11, 2'b01, 2'b00);
    checks++;
    if (obs !== 30'h0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs, 30'h0);
    end
  endtask

  task automatic test_prescaler();
    int nt;
    nt = 0;
    do_reset('0, '0, '0);
    for (int n = 1; n <= 20; n++) begin
      step('0, '0, '0);
      checks++;
      if (tick_w !== ((n % 4) == 0)) begin
        errors++; $display("FAIL prescaler_tick cyc=%0d got=%b exp=%b", n, tick_w, (n % 4) == 0);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL prescaler_vec cyc=%0d got=%h exp=%h", n, obs, exp_vec());
      end
      if (tick_w) nt++;
    end
    checks++;
    if (nt !== 5) begin
      errors++; $display("FAIL prescaler_count got=%0d exp=5", nt);
    end
  endtask

  task automatic test_basic_count();
    do_reset('0, '0, '0);
    step(2'b01, '0, '0);
    for (int k = 0; k < 40 && m_cw[0] != 5; k++) begin
      step('0, '0, '0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL basic_run_vec cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec());
      end
    end
    checks++;
    if ({cnt_w, run_w} !== {8'h05, 2'b01}) begin
      errors++; $display("FAIL basic_five got=%h/%b exp=05/01", cnt_w, run_w);
    end
    step('0, 2'b01, '0);
    checks++;
    if ({cnt_w[3:0], run_w[0], done_w} !== {4'd5, 1'b0, 2'b01}) begin
      errors++; $display("FAIL basic_stop got=%h/%b/%b exp=5/0/01", cnt_w[3:0], run_w[0], done_w);
    end
    for (int k = 0; k < 6; k++) begin
      step('0, (k < 2) ? 2'b01 : 2'b00, '0);
      checks++;
      if ({cnt_w[3:0], done_w} !== {4'd5, 2'b00}) begin
        errors++; $display("FAIL basic_hold cyc=%0d got=%h/%b exp=5/00", m_cyc, cnt_w[3:0], done_w);
      end
    end
    step(2'b01, '0, '0);
    for (int k = 0; k < 40 && m_cw[0] != 8; k++) begin
      step('0, '0, '0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL basic_lap_vec cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec());
      end
    end
    checks++;
    if ({cnt_w[3:0], cnt_s[3:0], run_w[0]} !== {4'd8, 4'd8, 1'b1}) begin
      errors++; $display("FAIL basic_lap got=%h/%h/%b exp=8/8/1", cnt_w[3:0], cnt_s[3:0], run_w[0]);
    end
  endtask

  task automatic test_coincide();
    do_reset('0, '0, '0);
    for (int k = 0; k < 8 && !m_tick(); k++) step('0, '0, '0);
    step(2'b01, '0, '0);
    checks++;
    if ({cnt_w[3:0], run_w[0]} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL start_on_tick got=%h/%b exp=0/1", cnt_w[3:0], run_w[0]);
    end
    for (int k = 0; k < 8 && !m_tick(); k++) step('0, '0, '0);
    step('0, 2'b01, 2'b01);
    checks++;
    if ({cnt_w[3:0], run_w[0], done_w[0]} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL stop_clear_on_tick got=%h/%b/%b exp=0/0/0", cnt_w[3:0], run_w[0], done_w[0]);
    end
    step(2'b01, '0, '0);
    for (int k = 0; k < 8 && !m_tick(); k++) step('0, '0, '0);
    step('0, '0, '0);
    for (int k = 0; k < 8 && !m_tick(); k++) step('0, '0, '0);
    step('0, 2'b01, '0);
    checks++;
    if ({cnt_w[3:0], run_w[0], done_w[0]} !== {4'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL stop_on_tick got=%h/%b/%b exp=1/0/1", cnt_w[3:0], run_w[0], done_w[0]);
    end
  endtask

  task automatic test_overflow();
    int nt;
    do_reset('0, '0, '0);
    step(2'b01, '0, '0);
    for (int k = 0; k < 200 && !(m_ovf[0] && m_cw[0] == 1); k++) begin
      step('0, '0, '0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL ovf_run_vec cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec());
      end
    end
    checks++;
    if ({cnt_w[3:0], ovf_w[0], run_w[0], cnt_s[3:0], ovf_s[0]} !== {4'd1, 1'b1, 1'b1, 4'd15, 1'b1}) begin
      errors++; $display("FAIL ovf_17 got=%h/%b/%b/%h/%b exp=1/1/1/f/1",
                         cnt_w[3:0], ovf_w[0], run_w[0], cnt_s[3:0], ovf_s[0]);
    end
    nt = 0;
    for (int k = 0; k < 40 && nt < 3; k++) begin
      if (m_tick()) nt++;
      step('0, '0, '0);
    end
    checks++;
    if ({cnt_s[3:0], ovf_s[0], run_s[0], cnt_w[3:0]} !== {4'd15, 1'b1, 1'b1, 4'd4}) begin
      errors++; $display("FAIL ovf_20 got=%h/%b/%b/%h exp=f/1/1/4", cnt_s[3:0], ovf_s[0], run_s[0], cnt_w[3:0]);
    end
    step('0, 2'b01, '0);
    step(2'b01, '0, '0);
    checks++;
    if ({ovf_w[0], ovf_s[0]} !== 2'b11) begin
      errors++; $display("FAIL ovf_sticky got=%b%b exp=11", ovf_w[0], ovf_s[0]);
    end
    step('0, '0, 2'b01);
    checks++;
    if ({ovf_w[0], ovf_s[0], cnt_w[3:0], cnt_s[3:0], run_w[0]} !== {2'b00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL ovf_clear got=%b%b/%h/%h/%b exp=00/0/0/0", ovf_w[0], ovf_s[0], cnt_w[3:0], cnt_s[3:0], run_w[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset('0, '0, '0);
    step(2'b11, '0, '0);
    for (int k = 0; k < 60 && m_cw[0] != 7; k++) step('0, '0, '0);
    checks++;
    if ({cnt_w, run_w} !== {8'h77, 2'b11}) begin
      errors++; $display("FAIL pre_reset got=%h/%b exp=77/11", cnt_w, run_w);
    end
    do_reset(2'b11, 2'b10, 2'b00);
    checks++;
    if (obs !== 30'h0) begin
      errors++; $display("FAIL mid_reset got=%h exp=%h", obs, 30'h0);
    end
    for (int n = 1; n <= 4; n++) begin
      step('0, '0, '0);
      checks++;
      if (tick_w !== (n == 4)) begin
        errors++; $display("FAIL reset_tick_restart cyc=%0d got=%b exp=%b", n, tick_w, n == 4);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] st, sp, cl;
    do_reset('0, '0, '0);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2'($urandom), 2'($urandom), 2'($urandom));
      end else begin
        for (int c = 0; c < 2; c++) begin
          st[c] = ($urandom_range(0, 9) == 0);
          sp[c] = ($urandom_range(0, 29) == 0);
          cl[c] = ($urandom_range(0, 99) == 0);
        end
        step(st, sp, cl);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_vec iter=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_prescaler();
    test_basic_count();
    test_coincide();
    test_overflow();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
